// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the ALU sequencer and the external 8-bit ALU:
//   - ALU opcode constants (0 = control / ALU idle, 1..7 = ALU operations)
//   - 16-bit instruction field bit positions
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package seq_pkg;

    // ALU opcodes; OP_CTRL doubles as "ALU idle" on the alu_inst bus
    localparam logic [2:0] OP_CTRL = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_SHL  = 3'd7;

    // Instruction layout: [15:13] op, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm
    localparam int unsigned OP_HI   = 15;
    localparam int unsigned OP_LO   = 13;
    localparam int unsigned RD_HI   = 12;
    localparam int unsigned RD_LO   = 11;
    localparam int unsigned RS_HI   = 10;
    localparam int unsigned RS_LO   = 9;
    localparam int unsigned SEL_BIT = 8;
    localparam int unsigned IMM_HI  = 7;
    localparam int unsigned IMM_LO  = 0;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HLT   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer_regfile.sv
// -----------------------------------------------------------------------------
// regfile_4x8
// Four 8-bit registers: two asynchronous read ports (a, b), one asynchronous
// debug read port, one synchronous write port. Synchronous active-high reset
// clears every register.
//   clk, rst          clock / synchronous reset
//   raddr_a, raddr_b  read addresses, rdata_a / rdata_b combinational
//   dbg_sel           debug read address, dbg_data combinational
//   we, waddr, wdata  write port, applied on the rising edge
// -----------------------------------------------------------------------------
module regfile_4x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    input  logic [1:0] dbg_sel,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    output logic [7:0] dbg_data
);

    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle FETCH / WAIT / EXEC / WB controller in front of an external
// combinational 8-bit ALU. Fetches 16-bit instructions, holds a 4x8 register
// file, drives the ALU opcode/operands during EXEC and writes the sampled
// result back in WB, keeping a zero flag. HALT parks the sequencer until rst.
//   clk, rst                     clock / synchronous active-high reset
//   run                          enables instruction fetch
//   imem_rd_en, imem_addr        one-cycle read strobe, address = pc
//   imem_data, imem_valid        returned instruction word + strobe
//   alu_inst, alu_op1, alu_op2   ALU opcode (0 = idle) and operands
//   alu_sol                      ALU result
//   dbg_sel, dbg_data            register read-back
//   zero, halted, pc             status
// -----------------------------------------------------------------------------
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned     PC_W    = 8,
    parameter logic [PC_W-1:0] INIT_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_rd_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            imem_valid,
    output logic [2:0]      alu_inst,
    output logic [7:0]      alu_op1,
    output logic [7:0]      alu_op2,
    input  logic [7:0]      alu_sol,
    input  logic [1:0]      dbg_sel,
    output logic [7:0]      dbg_data,
    output logic            zero,
    output logic            halted,
    output logic [PC_W-1:0] pc
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [7:0]      result_q, result_d;
    logic            zero_q, zero_d;
    logic            halted_q, halted_d;

    logic [2:0] op;
    logic [1:0] rd, rs;
    logic       imm_sel;
    logic [7:0] imm;
    logic       is_halt;
    logic [7:0] rd_data, rs_data;
    logic       rf_we;

    assign op      = ir_q[OP_HI:OP_LO];
    assign rd      = ir_q[RD_HI:RD_LO];
    assign rs      = ir_q[RS_HI:RS_LO];
    assign imm_sel = ir_q[SEL_BIT];
    assign imm     = ir_q[IMM_HI:IMM_LO];
    assign is_halt = (op == OP_CTRL) && imm_sel;

    regfile_4x8 u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rd),
        .raddr_b (rs),
        .dbg_sel (dbg_sel),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (result_q),
        .rdata_a (rd_data),
        .rdata_b (rs_data),
        .dbg_data(dbg_data)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        result_d   = result_q;
        zero_d     = zero_q;
        halted_d   = halted_q;
        imem_rd_en = 1'b0;
        alu_inst   = OP_CTRL;
        alu_op1    = '0;
        alu_op2    = '0;
        rf_we      = 1'b0;

        // Outputs are forced to their reset values while rst is high, so a
        // reset landing in FETCH/EXEC never leaks a strobe or an ALU opcode.
        if (!rst) begin
            unique case (state_q)
                ST_FETCH: begin
                    if (run && !halted_q) begin
                        imem_rd_en = 1'b1;
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        ir_d    = imem_data;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op != OP_CTRL) begin
                        alu_inst = op;
                        alu_op1  = rd_data;
                        alu_op2  = imm_sel ? imm : rs_data;
                        result_d = alu_sol;
                    end else begin
                        result_d = imm;
                    end
                    state_d = ST_WB;
                end
                ST_WB: begin
                    if (is_halt) begin
                        halted_d = 1'b1;
                        state_d  = ST_HLT;
                    end else begin
                        rf_we   = 1'b1;
                        zero_d  = (result_q == 8'h00);
                        pc_d    = pc_q + PC_W'(1);
                        state_d = ST_FETCH;
                    end
                end
                ST_HLT: begin
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= INIT_PC;
            ir_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign zero      = zero_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, run;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [2:0]  alu_inst;
    logic [7:0]  alu_op1, alu_op2, alu_sol;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic        zero, halted;
    logic [7:0]  pc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]      pc;
        logic [3:0][7:0] r;
        logic            z;
    } snap_t;

    typedef struct packed {
        logic [2:0] inst;
        logic [7:0] a;
        logic [7:0] b;
    } alu_t;

    snap_t snap_q[$];
    alu_t  alu_q[$];

    logic [15:0] mem [256];
    int unsigned lat [256];

    alu_sequencer #(.PC_W(8), .INIT_PC(8'd0)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_valid(imem_valid),
        .alu_inst(alu_inst), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_sol(alu_sol), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .zero(zero), .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    // External ALU; idle output is a marker value so a stray sample shows up
    always_comb begin
        case (alu_inst)
            OP_ADD:  alu_sol = alu_op1 + alu_op2;
            OP_SUB:  alu_sol = alu_op1 - alu_op2;
            OP_AND:  alu_sol = alu_op1 & alu_op2;
            OP_OR:   alu_sol = alu_op1 | alu_op2;
            OP_XOR:  alu_sol = alu_op1 ^ alu_op2;
            OP_NOT:  alu_sol = ~alu_op1;
            OP_SHL:  alu_sol = alu_op1 << alu_op2;
            default: alu_sol = 8'hA5;
        endcase
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_snap(input logic [7:0] p, input logic [7:0] r0, input logic [7:0] r1,
                             input logic [7:0] r2, input logic [7:0] r3, input logic z);
        snap_t s;
        s.pc = p;
        s.r  = {r3, r2, r1, r0};
        s.z  = z;
        snap_q.push_back(s);
    endtask

    task automatic push_alu(input logic [2:0] i, input logic [7:0] a, input logic [7:0] b);
        alu_t e;
        e.inst = i;
        e.a    = a;
        e.b    = b;
        alu_q.push_back(e);
    endtask

    // Instruction memory responder
    initial begin
        logic [7:0]  a;
        int unsigned d;
        imem_valid = 1'b0;
        imem_data  = '0;
        forever begin
            @(negedge clk);
            if (imem_rd_en && !rst) begin
                a = imem_addr;
                d = lat[a];
                @(posedge clk);
                for (int unsigned i = 1; i < d; i++) begin
                    @(negedge clk);
                    chk("wait_rd_en", 16'(imem_rd_en), 16'd0);
                    chk("wait_pc", 16'(pc), 16'(a));
                    @(posedge clk);
                end
                #1;
                imem_valid = 1'b1;
                imem_data  = mem[a];
                @(posedge clk);
                #1;
                imem_valid = 1'b0;
                imem_data  = '0;
            end
        end
    end

    // Monitor: ALU activity and architectural state at each fetch request
    initial begin
        alu_t  e;
        snap_t s;
        dbg_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst && alu_inst != OP_CTRL) begin
                if (alu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL alu_unexpected actual=%0h expected=0", alu_inst);
                end else begin
                    e = alu_q.pop_front();
                    chk("alu_inst", 16'(alu_inst), 16'(e.inst));
                    chk("alu_op1", 16'(alu_op1), 16'(e.a));
                    chk("alu_op2", 16'(alu_op2), 16'(e.b));
                end
            end
            if (!rst && imem_rd_en) begin
                if (snap_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected actual=pc%0h expected=none", pc);
                end else begin
                    s = snap_q.pop_front();
                    chk("fetch_pc", 16'(pc), 16'(s.pc));
                    chk("fetch_addr", 16'(imem_addr), 16'(s.pc));
                    chk("fetch_zero", 16'(zero), 16'(s.z));
                    chk("fetch_halted", 16'(halted), 16'd0);
                    for (int unsigned i = 0; i < 4; i++) begin
                        dbg_sel = 2'(i);
                        #1;
                        chk("fetch_reg", 16'(dbg_data), 16'(s.r[i]));
                    end
                    dbg_sel = 2'd0;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        for (int unsigned i = 0; i < 256; i++) begin
            mem[i] = 16'h0100;
            lat[i] = 1;
        end
        mem[0]  = 16'h0005;  // LDI r0,5
        mem[1]  = 16'h0803;  // LDI r1,3
        mem[2]  = 16'h2200;  // ADD r0,r1
        mem[3]  = 16'h4903;  // SUB r1,#3
        mem[4]  = 16'hC000;  // NOT r0
        mem[5]  = 16'h1081;  // LDI r2,0x81
        mem[6]  = 16'hF101;  // SHL r2,#1
        mem[7]  = 16'hF108;  // SHL r2,#8
        mem[8]  = 16'h18F0;  // LDI r3,0xF0
        mem[9]  = 16'h7800;  // AND r3,r0
        mem[10] = 16'hBE00;  // XOR r3,r3
        mem[11] = 16'h893C;  // OR  r1,#0x3C
        mem[12] = 16'h210A;  // ADD r0,#0x0A (slow return)
        mem[13] = 16'h0100;  // HALT
        lat[12] = 4;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pc", 16'(pc), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_zero", 16'(zero), 16'd0);
        chk("rst_alu_inst", 16'(alu_inst), 16'd0);
        chk("rst_alu_op1", 16'(alu_op1), 16'd0);
        chk("rst_alu_op2", 16'(alu_op2), 16'd0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_rd_en", 16'(imem_rd_en), 16'd0);
            @(negedge clk);
        end

        push_snap(8'd0,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        push_snap(8'd1,  8'h05, 8'h00, 8'h00, 8'h00, 1'b0);
        push_snap(8'd2,  8'h05, 8'h03, 8'h00, 8'h00, 1'b0);
        push_snap(8'd3,  8'h08, 8'h03, 8'h00, 8'h00, 1'b0);
        push_snap(8'd4,  8'h08, 8'h00, 8'h00, 8'h00, 1'b1);
        push_snap(8'd5,  8'hF7, 8'h00, 8'h00, 8'h00, 1'b0);
        push_snap(8'd6,  8'hF7, 8'h00, 8'h81, 8'h00, 1'b0);
        push_snap(8'd7,  8'hF7, 8'h00, 8'h02, 8'h00, 1'b0);
        push_snap(8'd8,  8'hF7, 8'h00, 8'h00, 8'h00, 1'b1);
        push_snap(8'd9,  8'hF7, 8'h00, 8'h00, 8'hF0, 1'b0);
        push_snap(8'd10, 8'hF7, 8'h00, 8'h00, 8'hF0, 1'b0);
        push_snap(8'd11, 8'hF7, 8'h00, 8'h00, 8'h00, 1'b1);
        push_snap(8'd12, 8'hF7, 8'h3C, 8'h00, 8'h00, 1'b0);
        push_snap(8'd13, 8'h01, 8'h3C, 8'h00, 8'h00, 1'b0);
        push_alu(OP_ADD, 8'h05, 8'h03);
        push_alu(OP_SUB, 8'h03, 8'h03);
        push_alu(OP_NOT, 8'h08, 8'h08);
        push_alu(OP_SHL, 8'h81, 8'h01);
        push_alu(OP_SHL, 8'h02, 8'h08);
        push_alu(OP_AND, 8'hF0, 8'hF7);
        push_alu(OP_XOR, 8'hF0, 8'hF0);
        push_alu(OP_OR,  8'h00, 8'h3C);
        push_alu(OP_ADD, 8'hF7, 8'h0A);

        @(posedge clk);
        #1 run = 1'b1;
        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        chk("halt_reached", 16'(halted), 16'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_rd_en", 16'(imem_rd_en), 16'd0);
            chk("halt_pc", 16'(pc), 16'd13);
        end
        chk("halt_zero", 16'(zero), 16'd0);
        chk("halt_alu_inst", 16'(alu_inst), 16'd0);
        chk("p1_snap_left", 16'(snap_q.size()), 16'd0);
        chk("p1_alu_left", 16'(alu_q.size()), 16'd0);

        // Reset out of HLT, then wrap the pc through 256 LDI r0,imm
        @(posedge clk);
        #1 rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst2_pc", 16'(pc), 16'd0);
        chk("rst2_halted", 16'(halted), 16'd0);
        chk("rst2_zero", 16'(zero), 16'd0);
        for (int unsigned i = 0; i < 256; i++) begin
            mem[i] = {8'h00, 8'(i)};
            lat[i] = 1;
        end
        push_snap(8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        push_snap(8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int unsigned k = 2; k < 256; k++) begin
            push_snap(8'(k), 8'(k - 1), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        push_snap(8'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);

        @(posedge clk);
        #1 run = 1'b1;
        for (int i = 0; i < 1500 && snap_q.size() != 0; i++) @(negedge clk);
        chk("p2_snap_left", 16'(snap_q.size()), 16'd0);
        @(posedge clk);
        #1 run = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rd_en", 16'(imem_rd_en), 16'd0);
        end
        chk("wrap_pc", 16'(pc), 16'd1);
        chk("wrap_zero", 16'(zero), 16'd1);
        chk("wrap_halted", 16'(halted), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
